// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl_if
// Description : Instruction-source handshake between the fetch side and the
//               multi-cycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
   logic       instr_valid;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       instr_ready;

   // master = instruction source, slave = controller
   modport master (
      output instr_valid,
      output opcode,
      output funct,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  opcode,
      input  funct,
      output instr_ready
   );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multi-cycle control FSM for the single-issue MIPS datapath;
//               drives datapath strobes and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
   parameter int COUNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_multicycle_ctrl_if.slave instr,
   input  logic                 zero,
   output logic                 ir_load,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 reg_write,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 alu_src,
   output logic [3:0]           alu_op,
   output logic                 illegal,
   output logic                 busy,
   output logic [COUNT_W-1:0]   retired
);

   localparam logic [5:0] C_OP_RTYPE = 6'b000000;
   localparam logic [5:0] C_OP_LW    = 6'b100011;
   localparam logic [5:0] C_OP_SW    = 6'b101011;
   localparam logic [5:0] C_OP_BEQ   = 6'b000100;
   localparam logic [5:0] C_OP_ADDI  = 6'b001000;

   localparam logic [5:0] C_FN_ADD   = 6'b100000;
   localparam logic [5:0] C_FN_SUB   = 6'b100010;
   localparam logic [5:0] C_FN_AND   = 6'b100100;
   localparam logic [5:0] C_FN_OR    = 6'b100101;

   localparam logic [3:0] C_ALU_ADD  = 4'b0010;
   localparam logic [3:0] C_ALU_SUB  = 4'b0110;
   localparam logic [3:0] C_ALU_AND  = 4'b0000;
   localparam logic [3:0] C_ALU_OR   = 4'b0001;

   localparam logic [COUNT_W-1:0] C_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [5:0]           opcode_q, opcode_d;
   logic [5:0]           funct_q, funct_d;
   logic [COUNT_W-1:0]   retired_q, retired_d;

   logic                 w_is_rtype;
   logic                 w_is_lw;
   logic                 w_is_sw;
   logic                 w_is_beq;
   logic                 w_is_addi;
   logic                 w_legal;
   logic [3:0]           w_class_alu_op;

   // Classification works only on the latched fields, never the live inputs
   always_comb begin
      w_is_rtype = (opcode_q == C_OP_RTYPE) &&
                   ((funct_q == C_FN_ADD) || (funct_q == C_FN_SUB) ||
                    (funct_q == C_FN_AND) || (funct_q == C_FN_OR));
      w_is_lw    = (opcode_q == C_OP_LW);
      w_is_sw    = (opcode_q == C_OP_SW);
      w_is_beq   = (opcode_q == C_OP_BEQ);
      w_is_addi  = (opcode_q == C_OP_ADDI);
      w_legal    = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_addi;
   end

   always_comb begin
      w_class_alu_op = C_ALU_ADD;
      if (w_is_beq) begin
         w_class_alu_op = C_ALU_SUB;
      end else if (w_is_rtype) begin
         case (funct_q)
            C_FN_SUB: w_class_alu_op = C_ALU_SUB;
            C_FN_AND: w_class_alu_op = C_ALU_AND;
            C_FN_OR:  w_class_alu_op = C_ALU_OR;
            default:  w_class_alu_op = C_ALU_ADD;
         endcase
      end
   end

   always_comb begin
      state_d           = state_q;
      opcode_d          = opcode_q;
      funct_d           = funct_q;
      retired_d         = retired_q;
      instr.instr_ready = 1'b0;
      ir_load           = 1'b0;
      pc_write          = 1'b0;
      pc_src            = 1'b0;
      reg_write         = 1'b0;
      reg_dst           = 1'b0;
      mem_to_reg        = 1'b0;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      alu_src           = 1'b0;
      alu_op            = 4'b0000;
      illegal           = 1'b0;
      busy              = 1'b1;

      case (state_q)
         S_FETCH: begin
            busy              = 1'b0;
            instr.instr_ready = 1'b1;
            if (instr.instr_valid) begin
               ir_load  = 1'b1;
               pc_write = 1'b1;
               opcode_d = instr.opcode;
               funct_d  = instr.funct;
               state_d  = S_DECODE;
            end
         end

         S_DECODE: begin
            if (w_legal) begin
               state_d = S_EXEC;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end

         S_EXEC: begin
            alu_op  = w_class_alu_op;
            alu_src = w_is_addi | w_is_lw | w_is_sw;
            if (w_is_beq) begin
               // Branch resolves on the live zero flag in this cycle only
               pc_write  = zero;
               pc_src    = zero;
               retired_d = retired_q + C_ONE;
               state_d   = S_FETCH;
            end else if (w_is_lw || w_is_sw) begin
               state_d = S_MEM;
            end else if (w_is_rtype || w_is_addi) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_MEM: begin
            alu_op  = C_ALU_ADD;
            alu_src = 1'b1;
            if (w_is_lw) begin
               mem_read = 1'b1;
               state_d  = S_WB;
            end else begin
               mem_write = w_is_sw;
               retired_d = retired_q + C_ONE;
               state_d   = S_FETCH;
            end
         end

         S_WB: begin
            alu_op     = w_class_alu_op;
            alu_src    = ~w_is_rtype;
            reg_write  = 1'b1;
            reg_dst    = w_is_rtype;
            mem_to_reg = w_is_lw;
            retired_d  = retired_q + C_ONE;
            state_d    = S_FETCH;
         end

         default: begin
            busy    = 1'b0;
            state_d = S_FETCH;
         end
      endcase

      // State is already FETCH under reset; suppress its handshake strobes too
      if (reset) begin
         instr.instr_ready = 1'b0;
         ir_load           = 1'b0;
         pc_write          = 1'b0;
         pc_src            = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         opcode_q  <= 6'd0;
         funct_q   <= 6'd0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         funct_q   <= funct_d;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed, self-checking bench for mips_multicycle_ctrl with an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

   localparam int COUNT_W = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               zero = 1'b0;
   logic               ir_load, pc_write, pc_src, reg_write, reg_dst, mem_to_reg;
   logic               mem_read, mem_write, alu_src, illegal, busy;
   logic [3:0]         alu_op;
   logic [COUNT_W-1:0] retired;

   int checks = 0;
   int errors = 0;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl #(.COUNT_W(COUNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (bus),
      .zero       (zero),
      .ir_load    (ir_load),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .busy       (busy),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rdy, ir, pcw, pcs, rw, rd, m2r, mr, mw, asrc;
      logic [3:0] aop;
      logic       ill, bsy;
   } outs_t;

   typedef struct {
      outs_t o;
      bit    branch;
      bit    retire;
   } step_t;

   step_t q[$];
   int    m_retired = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic outs_t actual();
      outs_t a;
      a = '{bus.instr_ready, ir_load, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
            mem_read, mem_write, alu_src, alu_op, illegal, busy};
      return a;
   endfunction

   // Expand one accepted instruction into the per-cycle outputs it must produce
   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
      int         cls;       // 0 illegal, 1 R, 2 addi, 3 lw, 4 sw, 5 beq
      logic [3:0] aop;
      step_t      s;
      cls = 0;
      aop = 4'b0010;
      case (op)
         6'b000000: begin
            cls = 1;
            case (fn)
               6'b100000: aop = 4'b0010;
               6'b100010: aop = 4'b0110;
               6'b100100: aop = 4'b0000;
               6'b100101: aop = 4'b0001;
               default:   cls = 0;
            endcase
         end
         6'b001000: cls = 2;
         6'b100011: cls = 3;
         6'b101011: cls = 4;
         6'b000100: begin cls = 5; aop = 4'b0110; end
         default:   cls = 0;
      endcase
      s.o = '0; s.o.bsy = 1'b1; s.branch = 0; s.retire = 0;
      if (cls == 0) begin
         s.o.ill = 1'b1;
         q.push_back(s);
         return;
      end
      q.push_back(s);
      s.o.aop = aop;
      s.o.asrc = (cls == 2 || cls == 3 || cls == 4);
      s.branch = (cls == 5);
      s.retire = (cls == 5);
      q.push_back(s);
      if (cls == 3 || cls == 4) begin
         s.o = '0; s.o.bsy = 1'b1; s.o.aop = 4'b0010; s.o.asrc = 1'b1;
         s.o.mr = (cls == 3); s.o.mw = (cls == 4);
         s.branch = 0; s.retire = (cls == 4);
         q.push_back(s);
      end
      if (cls == 1 || cls == 2 || cls == 3) begin
         s.o = '0; s.o.bsy = 1'b1; s.o.aop = aop; s.o.asrc = (cls != 1);
         s.o.rw = 1'b1; s.o.rd = (cls == 1); s.o.m2r = (cls == 3);
         s.branch = 0; s.retire = 1;
         q.push_back(s);
      end
   endtask

   always @(negedge clk) begin
      outs_t a, e;
      step_t s;
      a = actual();
      if (reset) begin
         q.delete();
         m_retired = 0;
         e = '0;
         a.rdy = 1'b0;
         chk("reset_outputs", 32'(a), 32'(e));
         chk("reset_retired", 32'(retired), 32'(0));
      end else begin
         if (q.size() == 0) begin
            e = '0;
            e.rdy = 1'b1;
            e.ir  = bus.instr_valid;
            e.pcw = bus.instr_valid;
         end else begin
            s = q[0];
            e = s.o;
            if (s.branch) begin
               e.pcw = zero;
               e.pcs = zero;
            end
         end
         chk("model_outputs", 32'(a), 32'(e));
         chk("model_retired", 32'(retired), 32'(m_retired % (1 << COUNT_W)));
         if (q.size() == 0) begin
            if (bus.instr_valid) push_instr(bus.opcode, bus.funct);
         end else begin
            s = q.pop_front();
            if (s.retire) m_retired++;
         end
      end
   end

   // Caller must be just after a rising edge with the DUT in FETCH
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input string name, input int exp_cycles, output int n);
      bit done;
      bus.instr_valid = 1'b1;
      bus.opcode = op;
      bus.funct  = fn;
      zero       = z;
      @(posedge clk); #1;
      bus.opcode = 6'h3f;
      bus.funct  = 6'h3f;
      n = 1;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.instr_ready) done = 1;
         else begin
            n++;
            @(posedge clk); #1;
         end
      end
      chk({name, "_timeout"}, 32'(done), 32'(1));
      chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
   endtask

   task automatic idle(input int cycles);
      bus.instr_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      int n, total;
      bus.instr_valid = 1'b0;
      bus.opcode = 6'd0;
      bus.funct  = 6'd0;

      @(posedge clk); #1;
      chk("reset_busy_lit", 32'(busy), 32'(0));
      chk("reset_retired_lit", 32'(retired), 32'(0));
      reset = 1'b0;
      #1;
      chk("ready_after_release", 32'(bus.instr_ready), 32'(1));

      run_instr(6'b000000, 6'b100000, 1'b1, "add", 4, n);
      idle(1);
      chk("retired_after_add", 32'(retired), 32'(1));

      run_instr(6'b100011, 6'b000000, 1'b0, "lw", 5, n);
      total = n;
      run_instr(6'b101011, 6'b000000, 1'b1, "sw", 4, n);
      total += n;
      idle(1);
      chk("lw_sw_total", 32'(total), 32'(9));
      chk("retired_after_lw_sw", 32'(retired), 32'(3));

      run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken", 3, n);
      run_instr(6'b000100, 6'b000000, 1'b0, "beq_not_taken", 3, n);
      idle(1);
      chk("retired_after_beq", 32'(retired), 32'(5));

      run_instr(6'b000000, 6'b100010, 1'b1, "sub", 4, n);
      run_instr(6'b000000, 6'b100100, 1'b0, "and", 4, n);
      run_instr(6'b000000, 6'b100101, 1'b1, "or", 4, n);
      run_instr(6'b001000, 6'b000000, 1'b1, "addi", 4, n);
      idle(1);
      chk("retired_after_alu", 32'(retired), 32'(9));

      run_instr(6'b111111, 6'b000000, 1'b0, "illegal_op", 2, n);
      run_instr(6'b000000, 6'b101010, 1'b0, "illegal_funct", 2, n);
      idle(1);
      chk("retired_after_illegal", 32'(retired), 32'(9));

      // Reset in the middle of a load, while it sits in MEM
      bus.instr_valid = 1'b1;
      bus.opcode = 6'b100011;
      bus.funct  = 6'd0;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("mid_lw_mem_read", 32'(mem_read), 32'(1));
      reset = 1'b1;
      #1;
      chk("mid_lw_mem_read_drop", 32'(mem_read), 32'(0));
      chk("mid_lw_busy", 32'(busy), 32'(0));
      chk("mid_lw_retired", 32'(retired), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      idle(6);

      for (int i = 0; i < 17; i++) run_instr(6'b001000, 6'b000101, 1'b1, "addi_wrap", 4, n);
      idle(2);
      chk("retired_wrap", 32'(retired), 32'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
